// File: rtl/alu_exec_stage.sv
// Registered RV32 execute-stage ALU feeding a DEPTH-entry result queue with valid/ready on both sides.
// Optional build macro ALU_EXT_OPS_EN adds xor (100), sll (110) and srl (111).
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
  } entry_t;

  // Handshake: a beat transfers on a rising edge where valid && ready are both high.
  // in_ready is a register (no path from out_ready); out_valid is simply count != 0.

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt_bit;
  entry_t           alu_entry;

  assign sum     = src_a + src_b;
  assign diff    = src_a - src_b;
  assign slt_bit = ($signed(src_a) < $signed(src_b));

`ifdef ALU_EXT_OPS_EN
  localparam int SH_W = $clog2(WIDTH);
  logic [SH_W-1:0] shamt;
  assign shamt = src_b[SH_W-1:0];
`endif

  always_comb begin
    alu_entry         = '0;
    alu_entry.illegal = 1'b0;
    unique case (alu_control)
      3'b000: begin
        alu_entry.result = sum;
        alu_entry.ovf    = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      3'b001: begin
        alu_entry.result = diff;
        alu_entry.ovf    = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      3'b010: alu_entry.result = src_a & src_b;
      3'b011: alu_entry.result = src_a | src_b;
      3'b101: alu_entry.result = {{(WIDTH-1){1'b0}}, slt_bit};
`ifdef ALU_EXT_OPS_EN
      3'b100: alu_entry.result = src_a ^ src_b;
      3'b110: alu_entry.result = src_a << shamt;
      3'b111: alu_entry.result = src_a >> shamt;
`endif
      default: alu_entry.illegal = 1'b1;
    endcase
    alu_entry.zero = (alu_entry.result == '0);
  end

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              in_ready_q;
  logic              push;
  logic              pop;
  entry_t            head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count      <= count_next;
      in_ready_q <= (count_next < CNT_W'(DEPTH));
    end
  end

  // Storage needs no reset: every head field is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= alu_entry;
  end

  assign head      = mem[rd_ptr];
  assign in_ready  = in_ready_q;
  assign out_valid = (count != '0);
  assign result    = out_valid ? head.result  : '0;
  assign zero      = out_valid ? head.zero    : 1'b0;
  assign ovf       = out_valid ? head.ovf     : 1'b0;
  assign illegal   = out_valid ? head.illegal : 1'b0;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed + random bench for alu_exec_stage: reference model feeds an expected queue,
// a negedge monitor pops and compares every beat the DUT hands out.
module tb_alu_exec_stage;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic [2:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         illegal;

  int tests = 0;
  int fails = 0;

  logic [W+2:0] exp_q[$];

  alu_exec_stage #(.WIDTH(W), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .ovf         (ovf),
    .illegal     (illegal)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: {result, zero, ovf, illegal}
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] c);
    logic [W-1:0] r;
    logic         v;
    logic         ill;
    r = '0; v = 1'b0; ill = 1'b0;
    case (c)
      3'd0: begin r = a + b; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      3'd1: begin r = a - b; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_EXT_OPS_EN
      3'd4: r = a ^ b;
      3'd6: r = a << b[4:0];
      3'd7: r = a >> b[4:0];
`endif
      default: ill = 1'b1;
    endcase
    return {r, (r == '0), v, ill};
  endfunction

  // scoreboard monitor: sample half a cycle away from the active edge
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("head_entry", {result, zero, ovf, illegal}, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(src_a, src_b, alu_control));
    end
  end

  // driver tasks
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    int   n;
    logic acc;
    src_a = a; src_b = b; alu_control = c; in_valid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    check("accepted", 64'(acc), 64'd1);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (out_valid !== 1'b0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drained", 64'(out_valid), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    src_a = '0; src_b = '0; alu_control = '0;

    // reset state
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_fields", {result, zero, ovf, illegal}, 64'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("in_ready_after_edge", 64'(in_ready), 64'd1);

    // add overflow, one-cycle latency
    out_ready = 1'b1;
    check("empty_out_valid", 64'(out_valid), 64'd0);
    send(32'h7FFF_FFFF, 32'h1, 3'b000);
    check("add_latency", 64'(out_valid), 64'd1);
    check("add_result", 64'(result), 64'h8000_0000);
    check("add_flags", {zero, ovf, illegal}, 64'b010);
    out_ready = 1'b0;
    wait_empty();

    // sub / slt directed
    out_ready = 1'b0;
    send(32'd5, 32'd5, 3'b001);
    check("sub_zero", {result, zero, ovf, illegal}, {32'd0, 3'b100});
    pop_one();
    send(32'hFFFF_FFFF, 32'd1, 3'b101);
    check("slt_neg", {result, zero}, {32'd1, 1'b0});
    pop_one();
    send(32'd1, 32'hFFFF_FFFF, 3'b101);
    check("slt_pos", {result, zero}, {32'd0, 1'b1});
    pop_one();
    send(32'h8000_0000, 32'd1, 3'b001);
    check("sub_ovf", {result, ovf}, {32'h7FFF_FFFF, 1'b1});
    pop_one();
    send(32'hF0F0_1234, 32'h0FF0_FF00, 3'b010);
    check("and_result", 64'(result), 64'h00F0_1200);
    pop_one();
    send(32'hF000_0001, 32'h0000_0F00, 3'b011);
    check("or_result", 64'(result), 64'hF000_0F01);
    pop_one();

    // code 111 with and without extended ops
    send(32'hF0, 32'd4, 3'b111);
`ifdef ALU_EXT_OPS_EN
    check("srl_code", {result, zero, ovf, illegal}, {32'h0F, 3'b000});
`else
    check("illegal_code", {result, zero, ovf, illegal}, {32'h0, 3'b101});
`endif
    pop_one();
    check("sb_after_directed", 64'(exp_q.size()), 64'd0);

    // backpressure: third beat held while full, then drain in order
    out_ready = 1'b0;
    send(32'd10, 32'd20, 3'b000);
    send(32'd30, 32'd4, 3'b001);
    check("full_in_ready", 64'(in_ready), 64'd0);
    src_a = 32'd7; src_b = 32'd9; alu_control = 3'b011; in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("held_in_ready", 64'(in_ready), 64'd0);
    check("held_head", {out_valid, result}, {1'b1, 32'd30});
    out_ready = 1'b1;
    begin
      int   n;
      logic acc;
      acc = 1'b0; n = 0;
      while (!acc && n < 20) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1; n++;
      end
      in_valid = 1'b0;
      check("third_accepted", 64'(acc), 64'd1);
    end
    wait_empty();

    // flush with one queued entry and a same-cycle push
    out_ready = 1'b0;
    send(32'd1, 32'd2, 3'b000);
    src_a = 32'd3; src_b = 32'd4; alu_control = 3'b000; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_state", {out_valid, in_ready, result}, {2'b01, 32'd0});
    @(posedge clk); #1;
    check("flush1_push_dropped", 64'(out_valid), 64'd0);

    // flush with full queue and in_valid high
    send(32'd11, 32'd12, 3'b000);
    send(32'd13, 32'd14, 3'b000);
    src_a = 32'd99; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_state", {out_valid, in_ready, zero, illegal}, 64'b0100);
    send(32'd100, 32'd23, 3'b001);
    check("post_flush_head", {out_valid, result}, {1'b1, 32'd77});
    wait_empty();

    // random stimulus with random backpressure
    for (int i = 0; i < 16; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send($urandom, (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
           3'($urandom_range(0, 7)));
    end
    wait_empty();

    // async reset with a full queue
    out_ready = 1'b0;
    send(32'd5, 32'd6, 3'b000);
    send(32'd7, 32'd8, 3'b000);
    #2 rst_n = 1'b0;
    #1 check("mid_reset_state", {out_valid, in_ready, result, zero, ovf, illegal}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("release_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("release_edge_in_ready", {in_ready, out_valid}, 64'b10);
    out_ready = 1'b1;
    send(32'h1234, 32'h1, 3'b000);
    check("post_reset_result", 64'(result), 64'h1235);
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
